// File: rtl/mac16_pkg.sv
// Shared types and the MAC16 configuration constant for driving the tile as a 16x16 dot-product
// accumulator.
package mac16_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StAccum,
        StDrain,
        StOut
    } dot_state_e;

    localparam int unsigned CBIT_W = 25;

    // CBIT field offsets
    localparam int unsigned CB_C_REG     = 0;
    localparam int unsigned CB_A_REG     = 1;
    localparam int unsigned CB_B_REG     = 2;
    localparam int unsigned CB_D_REG     = 3;
    localparam int unsigned CB_TOP8_REG  = 4;
    localparam int unsigned CB_BOT8_REG  = 5;
    localparam int unsigned CB_PIPE1_REG = 6;
    localparam int unsigned CB_PIPE2_REG = 7;
    localparam int unsigned CB_TOP_OSEL  = 8;   // 2 bits
    localparam int unsigned CB_TOP_ADDB  = 10;  // 2 bits
    localparam int unsigned CB_TOP_ADDA  = 12;
    localparam int unsigned CB_TOP_CSEL  = 13;  // 2 bits
    localparam int unsigned CB_BOT_OSEL  = 15;  // 2 bits
    localparam int unsigned CB_BOT_ADDB  = 17;  // 2 bits
    localparam int unsigned CB_BOT_ADDA  = 19;
    localparam int unsigned CB_BOT_CSEL  = 20;  // 2 bits
    localparam int unsigned CB_MODE8     = 22;
    localparam int unsigned CB_ASGND     = 23;
    localparam int unsigned CB_BSGND     = 24;

    localparam logic [1:0] OSEL_ACC     = 2'b01;
    localparam logic [1:0] ADDB_MUL16   = 2'b10;
    localparam logic       ADDA_ACC     = 1'b0;
    localparam logic [1:0] CSEL_ZERO    = 2'b00;
    localparam logic [1:0] CSEL_CASCADE = 2'b10;

    function automatic logic [CBIT_W-1:0] mac_cbit_dot(input logic sgn,
                                                       input int unsigned pipe_lat);
        logic [CBIT_W-1:0] c;
        c = '0;
        c[CB_A_REG]     = 1'b1;
        c[CB_B_REG]     = 1'b1;
        c[CB_PIPE2_REG] = (pipe_lat >= 3);
        c[CB_PIPE1_REG] = (pipe_lat >= 4);
        c[CB_TOP_OSEL +: 2] = OSEL_ACC;
        c[CB_BOT_OSEL +: 2] = OSEL_ACC;
        c[CB_TOP_ADDB +: 2] = ADDB_MUL16;
        c[CB_BOT_ADDB +: 2] = ADDB_MUL16;
        c[CB_TOP_ADDA]      = ADDA_ACC;
        c[CB_BOT_ADDA]      = ADDA_ACC;
        c[CB_TOP_CSEL +: 2] = CSEL_CASCADE;
        c[CB_BOT_CSEL +: 2] = CSEL_ZERO;
        c[CB_MODE8]         = 1'b0;
        c[CB_ASGND]         = sgn;
        c[CB_BSGND]         = sgn;
        return c;
    endfunction

endpackage

// File: rtl/mac16_valid_pipe.sv
// Shift-register tracker that follows accepted operand pairs through the tile pipeline.
module mac16_valid_pipe #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid_i,
    output logic tail_o,
    output logic empty_o
);

    logic [DEPTH-1:0] pipe_d, pipe_q;

    always_comb begin
        pipe_d = (pipe_q << 1) | DEPTH'(valid_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tail_o  = pipe_q[DEPTH-1];
    assign empty_o = ~|pipe_q;

endmodule

// File: rtl/mac16_dot_sequencer.sv
// Sequences one MAC16 tile through an N-term dot product and returns the accumulator result
// on a valid/ready stream.
module mac16_dot_sequencer
    import mac16_pkg::*;
#(
    parameter int unsigned LEN_W    = 8,
    parameter int unsigned PIPE_LAT = 3,
    parameter bit          SIGNED   = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [LEN_W-1:0]  CFG_LEN,
    input  logic              SUB_EN,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [15:0]       IN_A,
    input  logic [15:0]       IN_B,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [31:0]       OUT_DATA,
    output logic              BUSY,
    output logic [15:0]       MAC_A,
    output logic [15:0]       MAC_B,
    output logic              MAC_AHLD,
    output logic              MAC_BHLD,
    output logic              MAC_OHHLD,
    output logic              MAC_OLHLD,
    output logic              MAC_OHADS,
    output logic              MAC_OLADS,
    output logic              MAC_ORST,
    output logic              MAC_OLDA,
    output logic [CBIT_W-1:0] MAC_CBIT,
    input  logic [31:0]       MAC_O
);

    dot_state_e       state_d, state_q;
    logic [LEN_W-1:0] len_d, len_q;
    logic [LEN_W-1:0] cnt_d, cnt_q;
    logic             sub_d, sub_q;
    logic             in_ready_d, in_ready_q;
    logic             out_valid_d, out_valid_q;
    logic [31:0]      out_data_d, out_data_q;
    logic             accept;
    logic             trk_tail;
    logic             trk_empty;

    assign accept = IN_VALID & in_ready_q;

    // Depth excludes the accumulator register itself: the tail gates its enable.
    mac16_valid_pipe #(
        .DEPTH(PIPE_LAT - 1)
    ) u_valid_pipe (
        .clk_i  (CLK),
        .rst_i  (RST),
        .valid_i(accept),
        .tail_o (trk_tail),
        .empty_o(trk_empty)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        sub_d      = sub_q;
        out_data_d = out_data_q;
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    len_d   = CFG_LEN;
                    sub_d   = SUB_EN;
                    state_d = StClear;
                end
            end
            StClear: begin
                cnt_d = '0;
                if (len_q == '0) begin
                    out_data_d = '0;
                    state_d    = StOut;
                end else begin
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (accept) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_d == len_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (trk_empty) begin
                    out_data_d = MAC_O;
                    state_d    = StOut;
                end
            end
            StOut: begin
                if (OUT_READY) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        in_ready_d  = (state_d == StAccum);
        out_valid_d = (state_d == StOut);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            len_q       <= '0;
            cnt_q       <= '0;
            sub_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            sub_q       <= sub_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;
    assign BUSY      = (state_q != StIdle);

    assign MAC_A     = IN_A;
    assign MAC_B     = IN_B;
    assign MAC_AHLD  = ~accept;
    assign MAC_BHLD  = ~accept;
    assign MAC_OHHLD = ~trk_tail;
    assign MAC_OLHLD = ~trk_tail;
    assign MAC_OHADS = sub_q;
    assign MAC_OLADS = sub_q;
    assign MAC_ORST  = RST | (state_q == StClear);
    assign MAC_OLDA  = 1'b0;
    assign MAC_CBIT  = mac_cbit_dot(SIGNED, PIPE_LAT);

endmodule

// File: tb/tb_mac16_dot_sequencer.sv
// Bench for mac16_dot_sequencer with a behavioural MAC16 tile and a result scoreboard.
module tb_mac16_dot_sequencer;
    import mac16_pkg::*;

    localparam int unsigned LEN_W    = 8;
    localparam int unsigned PIPE_LAT = 3;
    localparam bit          SIGNED   = 1'b1;

    logic              CLK = 1'b0;
    logic              RST;
    logic              START;
    logic [LEN_W-1:0]  CFG_LEN;
    logic              SUB_EN;
    logic              IN_VALID;
    logic              IN_READY;
    logic [15:0]       IN_A, IN_B;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [31:0]       OUT_DATA;
    logic              BUSY;
    logic [15:0]       MAC_A, MAC_B;
    logic              MAC_AHLD, MAC_BHLD, MAC_OHHLD, MAC_OLHLD;
    logic              MAC_OHADS, MAC_OLADS, MAC_ORST, MAC_OLDA;
    logic [CBIT_W-1:0] MAC_CBIT;
    logic [31:0]       MAC_O;

    always #5 CLK = ~CLK;

    mac16_dot_sequencer #(
        .LEN_W   (LEN_W),
        .PIPE_LAT(PIPE_LAT),
        .SIGNED  (SIGNED)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .CFG_LEN  (CFG_LEN),
        .SUB_EN   (SUB_EN),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .IN_A     (IN_A),
        .IN_B     (IN_B),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .OUT_DATA (OUT_DATA),
        .BUSY     (BUSY),
        .MAC_A    (MAC_A),
        .MAC_B    (MAC_B),
        .MAC_AHLD (MAC_AHLD),
        .MAC_BHLD (MAC_BHLD),
        .MAC_OHHLD(MAC_OHHLD),
        .MAC_OLHLD(MAC_OLHLD),
        .MAC_OHADS(MAC_OHADS),
        .MAC_OLADS(MAC_OLADS),
        .MAC_ORST (MAC_ORST),
        .MAC_OLDA (MAC_OLDA),
        .MAC_CBIT (MAC_CBIT),
        .MAC_O    (MAC_O)
    );

    function automatic logic [31:0] mul16(input logic [15:0] a, input logic [15:0] b,
                                          input logic sa, input logic sb);
        logic signed [33:0] x, y, p;
        x = {{18{sa & a[15]}}, a};
        y = {{18{sb & b[15]}}, b};
        p = x * y;
        return p[31:0];
    endfunction

    // Tile model: input regs, one product pipeline reg, split-half accumulator.
    logic [15:0] a_r = '0, b_r = '0;
    logic [31:0] p_r = '0, acc_r = '0;
    logic [31:0] acc_sum, acc_dif;
    int          acc_en_cnt = 0;

    assign acc_sum = acc_r + p_r;
    assign acc_dif = acc_r - p_r;
    assign MAC_O   = acc_r;

    always @(posedge CLK) begin
        if (!MAC_AHLD) a_r <= MAC_A;
        if (!MAC_BHLD) b_r <= MAC_B;
        p_r <= mul16(a_r, b_r, MAC_CBIT[CB_ASGND], MAC_CBIT[CB_BSGND]);
        if (MAC_ORST) begin
            acc_r <= '0;
        end else begin
            if (!MAC_OLHLD) acc_r[15:0]  <= MAC_OLADS ? acc_dif[15:0]  : acc_sum[15:0];
            if (!MAC_OHHLD) acc_r[31:16] <= MAC_OHADS ? acc_dif[31:16] : acc_sum[31:16];
            if (!MAC_OHHLD) acc_en_cnt   <= acc_en_cnt + 1;
        end
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_results = 0;
    logic [31:0] sb_q[$];
    logic [15:0] op_a[16], op_b[16];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    always @(negedge CLK) begin
        if (!RST && OUT_VALID && OUT_READY) begin
            n_results++;
            if (sb_q.size() == 0) check_eq("unexpected_out", 32'(sb_q.size()), 32'd1);
            else check_eq("out_data", OUT_DATA, sb_q.pop_front());
        end
    end

    // All tasks are entered and left #1 after a rising edge.
    task automatic start_txn(input int n, input logic sub);
        START   = 1'b1;
        CFG_LEN = LEN_W'(n);
        SUB_EN  = sub;
        @(posedge CLK); #1;
        START   = 1'b0;
    endtask

    task automatic feed(input int n, input logic [15:0] vpat, input int vlen,
                        output int last_acc);
        int   k   = 0;
        int   idx = 0;
        logic acc;
        last_acc = 0;
        while (idx < n && k < 200) begin
            IN_VALID = (k < vlen) ? vpat[k[3:0]] : 1'b1;
            IN_A     = IN_VALID ? op_a[idx[3:0]] : 16'hDEAD;
            IN_B     = IN_VALID ? op_b[idx[3:0]] : 16'hBEEF;
            acc      = IN_VALID && IN_READY;
            @(posedge CLK); #1;
            if (acc) begin
                idx++;
                last_acc = cyc;
            end
            k++;
        end
        IN_VALID = 1'b0;
        check_eq("feed_accepts", 32'(idx), 32'(n));
    endtask

    task automatic wait_out(output int t_seen);
        int n = 0;
        t_seen = 0;
        @(negedge CLK);
        while (!OUT_VALID && n < 50) begin
            @(negedge CLK);
            n++;
        end
        t_seen = cyc + 1;
        check_eq("out_valid_seen", 32'(OUT_VALID), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int          t_acc, t_out, base;
        logic [31:0] exp;
        RST = 1'b1; START = 1'b0; CFG_LEN = '0; SUB_EN = 1'b0;
        IN_VALID = 1'b0; IN_A = '0; IN_B = '0; OUT_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_in_ready",  32'(IN_READY),  32'd0);
        check_eq("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check_eq("rst_out_data",  OUT_DATA,       32'd0);
        check_eq("rst_busy",      32'(BUSY),      32'd0);
        check_eq("rst_ahld",      32'(MAC_AHLD),  32'd1);
        check_eq("rst_bhld",      32'(MAC_BHLD),  32'd1);
        check_eq("rst_ohhld",     32'(MAC_OHHLD), 32'd1);
        check_eq("rst_olhld",     32'(MAC_OLHLD), 32'd1);
        check_eq("rst_ohads",     32'(MAC_OHADS), 32'd0);
        check_eq("rst_olads",     32'(MAC_OLADS), 32'd0);
        check_eq("rst_olda",      32'(MAC_OLDA),  32'd0);
        check_eq("rst_orst",      32'(MAC_ORST),  32'd1);
        check_eq("cbit_asgnd", 32'(MAC_CBIT[CB_ASGND]), 32'(SIGNED));
        check_eq("cbit_bsgnd", 32'(MAC_CBIT[CB_BSGND]), 32'(SIGNED));
        check_eq("cbit_mode8", 32'(MAC_CBIT[CB_MODE8]), 32'd0);
        check_eq("cbit_areg",  32'(MAC_CBIT[CB_A_REG]), 32'd1);
        RST = 1'b0;
        @(posedge CLK); #1;
        check_eq("idle_orst", 32'(MAC_ORST), 32'd0);

        // N=3 add, with output latency
        op_a[0] = 16'd1; op_a[1] = 16'd2; op_a[2] = 16'd3;
        op_b[0] = 16'd4; op_b[1] = 16'd5; op_b[2] = 16'd6;
        sb_q.push_back(32'h0000_0020);
        start_txn(3, 1'b0);
        feed(3, 16'hFFFF, 0, t_acc);
        wait_out(t_out);
        check_eq("t1_latency", 32'(t_out - t_acc), 32'(PIPE_LAT + 1));
        @(posedge CLK); #1;
        check_eq("t1_idle_busy", 32'(BUSY), 32'd0);

        // Same operands, subtract
        sb_q.push_back(32'hFFFF_FFE0);
        start_txn(3, 1'b1);
        feed(3, 16'hFFFF, 0, t_acc);
        wait_out(t_out);
        @(posedge CLK); #1;

        // Signed extremes
        op_a[0] = 16'hFFFF; op_a[1] = 16'h8000;
        op_b[0] = 16'h0002; op_b[1] = 16'h8000;
        sb_q.push_back(32'h3FFF_FFFE);
        start_txn(2, 1'b0);
        feed(2, 16'hFFFF, 0, t_acc);
        wait_out(t_out);
        @(posedge CLK); #1;

        // Bubbles plus output backpressure
        exp = '0;
        for (int i = 0; i < 4; i++) begin
            op_a[i] = 16'($urandom);
            op_b[i] = 16'($urandom);
            exp += mul16(op_a[i], op_b[i], SIGNED, SIGNED);
        end
        sb_q.push_back(exp);
        OUT_READY = 1'b0;
        base = acc_en_cnt;
        start_txn(4, 1'b0);
        @(posedge CLK); #1;
        feed(4, 16'h0059, 7, t_acc);
        wait_out(t_out);
        for (int i = 0; i < 5; i++) begin
            check_eq("t4_hold_valid", 32'(OUT_VALID), 32'd1);
            check_eq("t4_hold_data",  OUT_DATA,       exp);
            @(negedge CLK);
        end
        check_eq("t4_acc_enables", 32'(acc_en_cnt - base), 32'd4);
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
        @(posedge CLK); #1;

        // Zero-length vector
        sb_q.push_back(32'd0);
        start_txn(0, 1'b0);
        @(negedge CLK);
        check_eq("t5_clear_in_ready",  32'(IN_READY),  32'd0);
        check_eq("t5_clear_out_valid", 32'(OUT_VALID), 32'd0);
        @(negedge CLK);
        check_eq("t5_out_valid", 32'(OUT_VALID), 32'd1);
        check_eq("t5_in_ready",  32'(IN_READY),  32'd0);
        check_eq("t5_out_data",  OUT_DATA,       32'd0);
        @(posedge CLK); #1;

        // Abort after 2 of 5 accepts, then a fresh single term
        for (int i = 0; i < 5; i++) begin
            op_a[i] = 16'(i + 3);
            op_b[i] = 16'(i + 11);
        end
        start_txn(5, 1'b0);
        feed(2, 16'hFFFF, 0, t_acc);
        RST = 1'b1;
        @(posedge CLK); #1;
        check_eq("t6_busy",     32'(BUSY),     32'd0);
        check_eq("t6_in_ready", 32'(IN_READY), 32'd0);
        check_eq("t6_orst",     32'(MAC_ORST), 32'd1);
        RST = 1'b0;
        @(posedge CLK); #1;
        op_a[0] = 16'd7; op_b[0] = 16'd9;
        sb_q.push_back(32'd63);
        start_txn(1, 1'b0);
        feed(1, 16'hFFFF, 0, t_acc);
        wait_out(t_out);
        repeat (5) @(posedge CLK);
        #1;
        check_eq("result_count", 32'(n_results), 32'd6);
        check_eq("sb_empty",     32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
